mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset: synchronous, active-high.
REQ-003 rdy  in  1  chip ready; low = freeze all state, ram_wr forced 0.
REQ-004 if_req  in  1  instruction-fetch request; level, held until if_done.
REQ-005 if_addr  in  32  fetch byte address; stable while if_req high.
REQ-006 if_done  out  1  one-cycle pulse: fetch complete, if_data valid.
REQ-007 if_data  out  32  fetched word, little-endian.
REQ-008 mem_req  in  1  MEM-stage load/store request; level, held until mem_done.
REQ-009 mem_we  in  1  1 = store, 0 = load.
REQ-010 mem_addr  in  32  load/store byte address.
REQ-011 mem_len  in  2  size: 00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
REQ-012 mem_wdata  in  32  store data; byte i = bits [8i+7:8i].
REQ-013 mem_done  out  1  one-cycle pulse: load/store complete.
REQ-014 mem_rdata  out  32  load data, raw and zero-extended; sign extension is done in MEM.
REQ-015 busy  out  1  arbiter owns RAM port; drives pipeline stall.
REQ-016 ram_a  out  32  RAM byte address.
REQ-017 ram_wr  out  1  RAM write strobe.
REQ-018 ram_din  out  8  byte to RAM.
REQ-019 ram_dout  in  8  byte from RAM, valid one cycle after ram_a.

Function
REQ-020 FSM states: IDLE, XFER, TAIL, DONE.
REQ-021 IDLE, cycle C, both requests high: grant MEM.
  - Latch addr, len (IF forced to 4, read), wdata, we and owner.
  - Clear byte counter; go to XFER.
REQ-022 XFER, cycle C+1+i, i = 0..N-1: ram_a = addr+i (32-bit wrap); counter increments.
REQ-023 Store: in XFER, ram_wr = 1 and ram_din = byte i; after byte N-1, go to DONE.
REQ-024 Load: ram_dout captured into byte i-1 in cycle C+1+i.
  - After byte N-1, go to TAIL; TAIL captures byte N-1, then go to DONE.
REQ-025 DONE: owner's done pulses one cycle, data registered; next state IDLE.
  - Requests are ignored in DONE.
REQ-026 Latency from sample cycle C to done cycle:
  - load: N+2 cycles (word 6, half 4, byte 3);
  - store: N+1 cycles (word 5);
  - IF word: 6 cycles.
REQ-027 Earliest next request sample is the cycle after DONE; requesters deassert req registered on done.
REQ-028 A transaction is never preempted; a request arriving mid-transaction waits in IDLE.
REQ-029 Upper bytes beyond N in mem_rdata read as 0.
REQ-030 ram_wr = 0 outside XFER-store cycles.
REQ-031 ram_a holds its last value when idle.
REQ-032 busy = 1 in XFER, TAIL and DONE; 0 in IDLE.
REQ-033 rdy low in any state: no state, counter or capture change; ram_wr = 0; done pulse deferred.
  - A load byte due while rdy is low is recaptured after rdy returns; ram_a is held.

Reset
REQ-034 rst high at a clock edge: state IDLE, counter 0.
  - Outputs reset to 0: ram_a, ram_din, ram_wr, if_data, mem_rdata, if_done, mem_done, busy.
REQ-035 rst overrides rdy.
REQ-036 Reset mid-transaction aborts it: no done pulse, no further RAM writes.

Structure
REQ-037 Shared package holds:
  - FSM state encodings;
  - mem_len encodings (LEN_BYTE, LEN_HALF, LEN_WORD);
  - owner encoding (OWN_IF, OWN_MEM).
REQ-038 Single module, one FSM plus byte counter; no sub-module is warranted.

Verification
REQ-039 IF fetch 0x00000100, RAM bytes 13,05,00,00:
  - ram_a 0x100..0x103 in cycles C+1..C+4;
  - if_done in C+6; if_data = 0x00000513.
REQ-040 Store word 0xDEADBEEF at 0x20:
  - ram_wr high cycles C+1..C+4; ram_din EF,BE,AD,DE;
  - mem_done in C+5.
REQ-041 Load half at 0x1FFE, bytes 34,12:
  - mem_rdata = 0x00001234, mem_done in C+4.
  - Load byte at 0xFFFFFFFF: ram_a = 0xFFFFFFFF, done in C+3.
REQ-042 if_req and mem_req (load) rise together:
  - MEM served first;
  - IF sampled the cycle after mem_done, if_done 6 cycles later.
REQ-043 rdy low for 3 cycles mid-word-load: done delayed exactly 3 cycles, data unchanged.
REQ-044 rst in XFER of a store after 2 bytes:
  - no further ram_wr, no mem_done;
  - next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-serial RAM arbiter.
// Holds FSM states, access sizes and owner codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Number of bytes moved for a given size code.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        unique case (1'b1)
            (len == LEN_BYTE): n = 3'd1;
            (len == LEN_HALF): n = 3'd2;
            default:           n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and RAM-side bus of the arbiter.
// slave = arbiter view, master = pipeline/RAM view.
interface mem_arbiter_if;

    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    modport slave (
        input  rdy, if_req, if_addr,
        input  mem_req, mem_we, mem_addr,
        input  mem_len, mem_wdata, ram_dout,
        output if_done, if_data,
        output mem_done, mem_rdata, busy,
        output ram_a, ram_wr, ram_din
    );

    modport master (
        output rdy, if_req, if_addr,
        output mem_req, mem_we, mem_addr,
        output mem_len, mem_wdata, ram_dout,
        input  if_done, if_data,
        input  mem_done, mem_rdata, busy,
        input  ram_a, ram_wr, ram_din
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto a byte-wide RAM port.
// MEM wins ties; transfers run to completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_len;
    logic [31:0] r_wdata;
    logic        r_we;
    owner_t      r_owner;
    logic [31:0] r_buf;
    logic [31:0] r_ram_a;
    logic [7:0]  r_ram_din;
    logic [31:0] r_if_data;
    logic [31:0] r_mem_rdata;

    logic        w_grant;
    owner_t      w_own;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_sel_len;
    logic        w_sel_we;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_nbytes;
    logic        w_last;
    logic [1:0]  w_cap_idx;
    logic [1:0]  w_nxt_idx;
    logic [31:0] w_capt;
    logic        w_done;

    // A pending MEM request always beats a fetch.
    assign w_grant     = bus.if_req | bus.mem_req;
    assign w_own       = bus.mem_req ? OWN_MEM : OWN_IF;
    assign w_sel_addr  = bus.mem_req ? bus.mem_addr : bus.if_addr;
    assign w_sel_len   = bus.mem_req ? bus.mem_len : LEN_WORD;
    assign w_sel_we    = bus.mem_req & bus.mem_we;
    assign w_sel_wdata = bus.mem_req ? bus.mem_wdata : 32'd0;

    assign w_nbytes  = len_bytes(r_len);
    assign w_last    = (r_cnt == (w_nbytes - 3'd1));
    // RAM data lags the address by one cycle.
    assign w_cap_idx = r_cnt[1:0] - 2'd1;
    assign w_nxt_idx = r_cnt[1:0] + 2'd1;

    // Merge the incoming RAM byte into the read buffer.
    always_comb begin
        w_capt = r_buf;
        w_capt[{w_cap_idx, 3'b000} +: 8] = bus.ram_dout;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_last) begin
                    w_next = r_we ? ST_DONE : ST_TAIL;
                end
            end
            ST_TAIL: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register; rdy low freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (bus.rdy) begin
            r_state <= w_next;
        end
    end

    // Latch the request, step the RAM address and gather read bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_addr      <= 32'd0;
            r_len       <= LEN_BYTE;
            r_wdata     <= 32'd0;
            r_we        <= 1'b0;
            r_owner     <= OWN_IF;
            r_buf       <= 32'd0;
            r_ram_a     <= 32'd0;
            r_ram_din   <= 8'd0;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else if (bus.rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_own;
                        r_addr    <= w_sel_addr;
                        r_len     <= w_sel_len;
                        r_we      <= w_sel_we;
                        r_wdata   <= w_sel_wdata;
                        r_cnt     <= 3'd0;
                        r_buf     <= 32'd0;
                        r_ram_a   <= w_sel_addr;
                        r_ram_din <= w_sel_wdata[7:0];
                    end
                end
                ST_XFER: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (!r_we && (r_cnt != 3'd0)) begin
                        r_buf <= w_capt;
                    end
                    if (!w_last) begin
                        r_ram_a   <= r_addr + {29'd0, r_cnt} + 32'd1;
                        r_ram_din <= r_wdata[{w_nxt_idx, 3'b000} +: 8];
                    end
                end
                ST_TAIL: begin
                    r_buf <= w_capt;
                    if (r_owner == OWN_MEM) begin
                        r_mem_rdata <= w_capt;
                    end else begin
                        r_if_data <= w_capt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes are gated so that stalls and reset never leak a pulse.
    assign w_done        = (r_state == ST_DONE) & bus.rdy & ~rst;
    assign bus.if_done   = w_done & (r_owner == OWN_IF);
    assign bus.mem_done  = w_done & (r_owner == OWN_MEM);
    assign bus.if_data   = r_if_data;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.ram_a     = r_ram_a;
    assign bus.ram_din   = r_ram_din;
    assign bus.ram_wr    = (r_state == ST_XFER) & r_we & bus.rdy & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus
// hand-written arbitration, stall and reset sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] exp;
        int          lat;
        int          n;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vt [NVEC];

    logic [7:0] mem [logic [31:0]];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // Byte RAM sharing the chip rdy: frozen while rdy is low.
    always @(posedge clk) begin
        if (bus.rdy) begin
            if (bus.ram_wr) mem[bus.ram_a] = bus.ram_din;
            bus.ram_dout <= rd(bus.ram_a);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) begin
            mem[a + 32'(j)] = w[8*j +: 8];
        end
    endtask

    function automatic logic [31:0] rd32(input logic [31:0] a);
        return {rd(a + 32'd3), rd(a + 32'd2), rd(a + 32'd1), rd(a)};
    endfunction

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int done_at;
        int wrong;
        logic [31:0] sh;
        logic own_done;
        logic oth_done;
        done_at = 0;
        wrong = 0;
        preload(v.addr, v.pre);
        step();
        bus.mem_len = v.len;
        if (v.is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = v.we;
            bus.mem_addr  = v.addr;
            bus.mem_wdata = v.wdata;
        end
        settle();
        chk($sformatf("v%0d busy_c", id), 32'(bus.busy), 32'd0);
        for (int k = 1; k <= v.lat + 4; k++) begin
            step();
            if (done_at != 0) idle_inputs();
            settle();
            if (done_at != 0) begin
                chk($sformatf("v%0d busy_after", id), 32'(bus.busy), 32'd0);
                chk($sformatf("v%0d ram_a_hold", id), bus.ram_a,
                    v.addr + 32'(v.n - 1));
                break;
            end
            if (k <= v.n) begin
                chk($sformatf("v%0d ram_a k%0d", id, k), bus.ram_a,
                    v.addr + 32'(k - 1));
                chk($sformatf("v%0d ram_wr k%0d", id, k), 32'(bus.ram_wr),
                    32'(v.we));
                if (v.we) begin
                    sh = v.wdata >> (8 * (k - 1));
                    chk($sformatf("v%0d ram_din k%0d", id, k),
                        32'(bus.ram_din), 32'(sh[7:0]));
                end
            end
            own_done = v.is_if ? bus.if_done : bus.mem_done;
            oth_done = v.is_if ? bus.mem_done : bus.if_done;
            if (oth_done) wrong++;
            if (own_done && done_at == 0) begin
                done_at = k;
                if (!v.we) begin
                    chk($sformatf("v%0d data", id),
                        v.is_if ? bus.if_data : bus.mem_rdata, v.exp);
                end
            end
        end
        idle_inputs();
        chk($sformatf("v%0d latency", id), 32'(done_at), 32'(v.lat));
        chk($sformatf("v%0d other_done", id), 32'(wrong), 32'd0);
        if (v.we) begin
            chk($sformatf("v%0d ram_after", id), rd32(v.addr), v.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        int md;
        int idn;
        int dn;
        int wr_seen;

        vt[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,
                   32'h0000_0513, 32'h0000_0513, 6, 4};
        vt[1]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF,
                   32'h0000_0000, 32'hDEAD_BEEF, 5, 4};
        vt[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_1FFE, 32'h0,
                   32'hFFFF_1234, 32'h0000_1234, 4, 2};
        vt[3]  = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,
                   32'h6655_44AB, 32'h0000_00AB, 3, 1};
        vt[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,
                   32'h1234_5678, 32'h1234_5678, 6, 4};
        vt[5]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0080, 32'h1122_3355,
                   32'h9999_9999, 32'h9999_9955, 2, 1};
        vt[6]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0090, 32'hAAAA_CAFE,
                   32'h7777_7777, 32'h7777_CAFE, 3, 2};
        vt[7]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0050, 32'h0,
                   32'hA1B2_C3D4, 32'hA1B2_C3D4, 6, 4};
        vt[8]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,
                   32'h8877_EEFF, 32'h8877_EEFF, 6, 4};
        vt[9]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0084, 32'h0,
                   32'hF0E0_D0C5, 32'h0000_00C5, 3, 1};
        vt[10] = '{1'b1, 1'b0, 2'b00, 32'h0000_0200, 32'h0,
                   32'hCAFE_BABE, 32'hCAFE_BABE, 6, 4};

        rst           = 1'b1;
        bus.rdy       = 1'b1;
        bus.if_addr   = 32'h0;
        bus.mem_addr  = 32'h0;
        bus.mem_len   = 2'b00;
        bus.mem_wdata = 32'h0;
        bus.ram_dout  = 8'h00;
        idle_inputs();
        step();
        step();
        settle();
        chk("rst ram_a", bus.ram_a, 32'h0);
        chk("rst ram_din", 32'(bus.ram_din), 32'h0);
        chk("rst ram_wr", 32'(bus.ram_wr), 32'h0);
        chk("rst if_data", bus.if_data, 32'h0);
        chk("rst mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst dones", {30'd0, bus.if_done, bus.mem_done}, 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        step();
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vt[i], i);
        end

        // Simultaneous requests: MEM load first, then the fetch.
        preload(32'h40, 32'h1234_5678);
        preload(32'h100, 32'h0000_0513);
        md = 0;
        idn = 0;
        step();
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h40;
        bus.mem_len  = LEN_WORD;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h100;
        settle();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (md != 0) bus.mem_req = 1'b0;
            if (idn != 0) bus.if_req = 1'b0;
            settle();
            if (idn != 0) break;
            if (md != 0 && k == md + 1) begin
                chk("tie busy_gap", 32'(bus.busy), 32'd0);
            end
            if (md != 0 && k == md + 2) begin
                chk("tie if ram_a", bus.ram_a, 32'h100);
            end
            if (bus.mem_done && md == 0) begin
                md = k;
                chk("tie mem_rdata", bus.mem_rdata, 32'h1234_5678);
            end
            if (bus.if_done && idn == 0) begin
                idn = k;
                chk("tie if_data", bus.if_data, 32'h0000_0513);
            end
        end
        idle_inputs();
        chk("tie mem_done cyc", 32'(md), 32'd6);
        chk("tie if_done cyc", 32'(idn), 32'd13);

        // rdy low for three cycles in the middle of a word load.
        dn = 0;
        step();
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h40;
        bus.mem_len  = LEN_WORD;
        settle();
        for (int k = 1; k <= 14; k++) begin
            step();
            bus.rdy = !(k >= 3 && k <= 5);
            if (dn != 0) bus.mem_req = 1'b0;
            settle();
            if (dn != 0) break;
            if (k >= 3 && k <= 5) begin
                chk($sformatf("stall ram_a k%0d", k), bus.ram_a, 32'h42);
                chk($sformatf("stall done k%0d", k), 32'(bus.mem_done), 32'd0);
            end
            if (bus.mem_done && dn == 0) begin
                dn = k;
                chk("stall data", bus.mem_rdata, 32'h1234_5678);
            end
        end
        idle_inputs();
        bus.rdy = 1'b1;
        chk("stall done cyc", 32'(dn), 32'd9);

        // Store word with rdy dropped once in XFER and once in DONE.
        preload(32'hC0, 32'h0);
        dn = 0;
        step();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'hC0;
        bus.mem_len   = LEN_WORD;
        bus.mem_wdata = 32'h0BAD_F00D;
        settle();
        for (int k = 1; k <= 12; k++) begin
            step();
            bus.rdy = !(k == 2 || k == 6);
            if (dn != 0) bus.mem_req = 1'b0;
            settle();
            if (dn != 0) break;
            if (k == 2 || k == 6) begin
                chk($sformatf("st_stall ram_wr k%0d", k), 32'(bus.ram_wr), 32'd0);
                chk($sformatf("st_stall done k%0d", k), 32'(bus.mem_done), 32'd0);
            end
            if (bus.mem_done && dn == 0) dn = k;
        end
        idle_inputs();
        bus.rdy = 1'b1;
        chk("st_stall done cyc", 32'(dn), 32'd7);
        chk("st_stall ram", rd32(32'hC0), 32'h0BAD_F00D);

        // Reset during a word store after two bytes.
        preload(32'hA0, 32'h0);
        wr_seen = 0;
        dn = 0;
        step();
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'hA0;
        bus.mem_len   = LEN_WORD;
        bus.mem_wdata = 32'h4433_2211;
        settle();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                idle_inputs();
            end
            settle();
            if (k <= 2) chk($sformatf("rst_st wr k%0d", k), 32'(bus.ram_wr), 32'd1);
            if (k == 3) chk("rst_st wr in rst", 32'(bus.ram_wr), 32'd0);
            if (k == 4) begin
                chk("rst_st ram_a", bus.ram_a, 32'h0);
                chk("rst_st ram_din", 32'(bus.ram_din), 32'h0);
                chk("rst_st mem_rdata", bus.mem_rdata, 32'h0);
                chk("rst_st if_data", bus.if_data, 32'h0);
                chk("rst_st busy", 32'(bus.busy), 32'h0);
            end
            if (k >= 4 && bus.ram_wr) wr_seen++;
            if (k >= 3 && (bus.mem_done || bus.if_done)) dn++;
        end
        chk("rst_st late writes", 32'(wr_seen), 32'd0);
        chk("rst_st done pulses", 32'(dn), 32'd0);
        chk("rst_st ram", rd32(32'hA0), 32'h0000_2211);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
